// File: rtl/wash_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : wash_scheduler
//  Description : Washing-machine program sequencer. Steps through the INLET,
//                WASH, DRAIN and DRY phases of the selected program, skipping
//                phases with a zero duration. It counts down the seconds of each
//                phase on the 1 Hz tick. It supports pause/resume and a
//                latched emergency stop.
//
//  Ports       : clk          - system clock, rising edge active
//                rst          - synchronous active-high reset
//                tick         - one-clk 1 Hz enable
//                start_p      - start / pause / resume / acknowledge key pulse
//                select_p     - program select key pulse (IDLE only)
//                emergency_p  - emergency stop key pulse
//                mode[1:0]    - selected program
//                count[5:0]   - remaining seconds of the current phase
//                inlet, wash, drain, dry - phase actuator enables
//                zheng, fan   - motor forward / reverse
//                alarm        - done or emergency indicator
//                busy         - high whenever not IDLE
//
//  Revision    : 1.0 - initial release
// ============================================================================
module wash_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_p,
    input  logic       select_p,
    input  logic       emergency_p,
    output logic [1:0] mode,
    output logic [5:0] count,
    output logic       inlet,
    output logic       wash,
    output logic       drain,
    output logic       dry,
    output logic       zheng,
    output logic       fan,
    output logic       alarm,
    output logic       busy
);

    // Active phases are encoded 1..4 so that (state - 1) is the phase index
    // and the state value itself is the index of the following phase.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INLET = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_DRY   = 3'd4,
        S_PAUSE = 3'd5,
        S_DONE  = 3'd6,
        S_ESTOP = 3'd7
    } state_t;

    // Duration in seconds of phase p (0=inlet .. 3=dry) for program m.
    function automatic logic [5:0] phase_dur(input logic [1:0] m, input logic [1:0] p);
        logic [5:0] d;
        d = 6'd0;
        case (m)
            2'd0: d = (p == 2'd1) ? 6'd12 : 6'd6;
            2'd1: d = (p == 2'd1) ? 6'd8  : 6'd4;
            2'd2: d = (p == 2'd1) ? 6'd20 : 6'd8;
            default: d = (p == 2'd3) ? 6'd10 : 6'd0;
        endcase
        return d;
    endfunction

    // First phase with index >= first_idx that has a non-zero duration;
    // S_DONE when the program has no such phase left.
    function automatic state_t next_active(input logic [1:0] m, input logic [2:0] first_idx);
        state_t s;
        logic   found;
        s     = S_DONE;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && (3'(i) >= first_idx) && (phase_dur(m, 2'(i)) != 6'd0)) begin
                s     = state_t'(3'(i) + 3'd1);
                found = 1'b1;
            end
        end
        return s;
    endfunction

    // Load value for count on entry to state s (0 for DONE).
    function automatic logic [5:0] state_dur(input logic [1:0] m, input state_t s);
        logic [2:0] v;
        logic [2:0] idx;
        v   = s;
        idx = v - 3'd1;
        if ((s == S_INLET) || (s == S_WASH) || (s == S_DRAIN) || (s == S_DRY)) begin
            return phase_dur(m, idx[1:0]);
        end
        return 6'd0;
    endfunction

    state_t     r_state;
    state_t     r_saved;
    logic [1:0] r_mode;
    logic [5:0] r_count;
    logic [2:0] r_mcnt;
    logic       r_inlet, r_wash, r_drain, r_dry, r_zheng, r_fan, r_alarm, r_busy;

    state_t     w_state_nxt;
    state_t     w_saved_nxt;
    state_t     w_adv;
    logic [1:0] w_mode_nxt;
    logic [5:0] w_count_nxt;
    logic [2:0] w_mcnt_nxt;
    logic       w_active;

    assign w_active = (r_state == S_INLET) || (r_state == S_WASH) ||
                      (r_state == S_DRAIN) || (r_state == S_DRY);

    // Next-state logic; priority emergency > start > tick > select, with
    // lower-priority events in the same cycle dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        w_mode_nxt  = r_mode;
        w_count_nxt = r_count;
        w_mcnt_nxt  = r_mcnt;
        w_adv       = next_active(r_mode, 3'(r_state));

        if (r_state == S_IDLE) begin
            // emergency_p has no meaning before a program is running
            if (start_p) begin
                w_state_nxt = next_active(r_mode, 3'd0);
                w_count_nxt = state_dur(r_mode, w_state_nxt);
            end else if (!tick && select_p) begin
                w_mode_nxt = r_mode + 2'd1;
            end
        end else if (w_active) begin
            if (emergency_p) begin
                w_state_nxt = S_ESTOP;
            end else if (start_p) begin
                w_state_nxt = S_PAUSE;
                w_saved_nxt = r_state;
            end else if (tick) begin
                if (r_count > 6'd1) begin
                    w_count_nxt = r_count - 6'd1;
                    if (r_state == S_WASH) begin
                        w_mcnt_nxt = r_mcnt + 3'd1;
                    end
                end else begin
                    w_state_nxt = w_adv;
                    w_count_nxt = state_dur(r_mode, w_adv);
                end
            end
        end else if ((r_state == S_PAUSE) || (r_state == S_DONE)) begin
            if (emergency_p) begin
                w_state_nxt = S_ESTOP;
            end else if (start_p) begin
                w_state_nxt = (r_state == S_PAUSE) ? r_saved : S_IDLE;
            end
        end
        // S_ESTOP holds everything until reset

        // Fresh entry into WASH restarts the motor pattern; resuming from
        // PAUSE keeps the frozen position.
        if ((w_state_nxt == S_WASH) && (r_state != S_WASH) && (r_state != S_PAUSE)) begin
            w_mcnt_nxt = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_saved <= S_IDLE;
            r_mode  <= 2'd0;
            r_count <= 6'd0;
            r_mcnt  <= 3'd0;
            r_inlet <= 1'b0;
            r_wash  <= 1'b0;
            r_drain <= 1'b0;
            r_dry   <= 1'b0;
            r_zheng <= 1'b0;
            r_fan   <= 1'b0;
            r_alarm <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
            r_mode  <= w_mode_nxt;
            r_count <= w_count_nxt;
            r_mcnt  <= w_mcnt_nxt;
            r_inlet <= (w_state_nxt == S_INLET);
            r_wash  <= (w_state_nxt == S_WASH);
            r_drain <= (w_state_nxt == S_DRAIN) || (w_state_nxt == S_ESTOP);
            r_dry   <= (w_state_nxt == S_DRY);
            r_zheng <= (w_state_nxt == S_WASH) && !w_mcnt_nxt[2];
            r_fan   <= (w_state_nxt == S_WASH) &&  w_mcnt_nxt[2];
            r_alarm <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ESTOP);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign mode  = r_mode;
    assign count = r_count;
    assign inlet = r_inlet;
    assign wash  = r_wash;
    assign drain = r_drain;
    assign dry   = r_dry;
    assign zheng = r_zheng;
    assign fan   = r_fan;
    assign alarm = r_alarm;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wash_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_wash_scheduler
//  Description : Self-checking bench for wash_scheduler. A driver applies one
//                stimulus vector per cycle and pushes the reference model's
//                expected outputs into a queue. A monitor pops one entry per
//                cycle and compares it against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start_p = 1'b0;
    logic       select_p = 1'b0;
    logic       emergency_p = 1'b0;
    logic [1:0] mode;
    logic [5:0] count;
    logic       inlet, wash, drain, dry, zheng, fan, alarm, busy;

    wash_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start_p     (start_p),
        .select_p    (select_p),
        .emergency_p (emergency_p),
        .mode        (mode),
        .count       (count),
        .inlet       (inlet),
        .wash        (wash),
        .drain       (drain),
        .dry         (dry),
        .zheng       (zheng),
        .fan         (fan),
        .alarm       (alarm),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] count;
        logic [7:0] act;   // {inlet,wash,drain,dry,zheng,fan,alarm,busy}
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- reference model (program as a list of phases) --------
    localparam int c_idle   = 0;
    localparam int c_run    = 1;
    localparam int c_paused = 2;
    localparam int c_done   = 3;
    localparam int c_estop  = 4;

    int m_stat  = c_idle;
    int m_mode  = 0;
    int m_count = 0;
    int m_wash  = 0;     // ticks elapsed in the current WASH visit
    int m_plan[$];       // phases still to run; m_plan[0] is the current one

    function automatic int dur_of(int m, int p);
        int t[16] = '{6, 12, 6, 6,  4, 8, 4, 4,  8, 20, 8, 8,  0, 0, 0, 10};
        return t[m * 4 + p];
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit sl, input bit em);
        if (r) begin
            m_stat = c_idle; m_mode = 0; m_count = 0; m_wash = 0; m_plan.delete();
        end else begin
            case (m_stat)
                c_idle: begin
                    if (s) begin
                        m_plan.delete();
                        for (int p = 0; p < 4; p++)
                            if (dur_of(m_mode, p) != 0) m_plan.push_back(p);
                        m_stat  = c_run;
                        m_count = dur_of(m_mode, m_plan[0]);
                        m_wash  = 0;
                    end else if (!t && sl) begin
                        m_mode = (m_mode + 1) % 4;
                    end
                end
                c_run: begin
                    if (em) m_stat = c_estop;
                    else if (s) m_stat = c_paused;
                    else if (t) begin
                        if (m_count > 1) begin
                            m_count--;
                            if (m_plan[0] == 1) m_wash++;
                        end else begin
                            void'(m_plan.pop_front());
                            if (m_plan.size() == 0) begin
                                m_stat = c_done; m_count = 0;
                            end else begin
                                m_count = dur_of(m_mode, m_plan[0]);
                                m_wash  = 0;
                            end
                        end
                    end
                end
                c_paused: begin
                    if (em) m_stat = c_estop;
                    else if (s) m_stat = c_run;
                end
                c_done: begin
                    if (em) m_stat = c_estop;
                    else if (s) m_stat = c_idle;
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   run;
        int   ph;
        run = (m_stat == c_run);
        ph  = run ? m_plan[0] : -1;
        e.mode   = 2'(m_mode);
        e.count  = 6'(m_count);
        e.act[7] = (ph == 0);
        e.act[6] = (ph == 1);
        e.act[5] = (ph == 2) || (m_stat == c_estop);
        e.act[4] = (ph == 3);
        e.act[3] = (ph == 1) && ((m_wash % 8) < 4);
        e.act[2] = (ph == 1) && ((m_wash % 8) >= 4);
        e.act[1] = (m_stat == c_done) || (m_stat == c_estop);
        e.act[0] = (m_stat != c_idle);
        return e;
    endfunction

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("mode", int'(mode), int'(mon_e.mode));
            check("count", int'(count), int'(mon_e.count));
            check("actuators", int'({inlet, wash, drain, dry, zheng, fan, alarm, busy}),
                  int'(mon_e.act));
            if (zheng && fan) check("motor_exclusive", 1, 0);
        end
    end

    // ---------------- driver ------------------------------------------------
    task automatic cyc(input bit r, input bit t, input bit s, input bit sl, input bit em);
        @(negedge clk);
        rst = r; tick = t; start_p = s; select_p = sl; emergency_p = em;
        model_step(r, t, s, sl, em);
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0);
            idle(int'($urandom_range(0, 1)));
        end
    endtask

    function automatic int acts();
        return int'({inlet, wash, drain, dry, zheng, fan, alarm, busy});
    endfunction

    initial begin
        int estop_run;
        bit r, t, s, sl, em;

        // reset
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("reset_acts", acts(), 0);
        check("reset_count", int'(count), 0);
        check("reset_mode", int'(mode), 0);

        // full mode0 program
        cyc(0, 0, 1, 0, 0);
        check("m0_start_count", int'(count), 6);
        check("m0_start_inlet", int'(inlet), 1);
        ticks(30);
        check("m0_done_acts", acts(), 8'b0000_0011);
        check("m0_done_count", int'(count), 0);
        cyc(0, 0, 1, 0, 0);
        check("m0_back_idle", acts(), 0);

        // mode3 goes straight to DRY
        repeat (3) begin cyc(0, 0, 0, 1, 0); idle(1); end
        check("m3_mode", int'(mode), 3);
        cyc(0, 0, 1, 0, 0);
        check("m3_dry_acts", acts(), 8'b0001_0001);
        check("m3_dry_count", int'(count), 10);
        ticks(10);
        check("m3_done_alarm", int'(alarm), 1);
        cyc(0, 0, 1, 0, 0);

        // wrap 3 -> 0, then four more selects return to 0
        cyc(0, 0, 0, 1, 0);
        check("wrap_mode", int'(mode), 0);
        repeat (4) cyc(0, 0, 0, 1, 0);
        check("wrap4_mode", int'(mode), 0);

        // select ignored in WASH, pause at WASH count 7
        cyc(0, 0, 1, 0, 0);
        ticks(6);
        cyc(0, 0, 0, 1, 0);
        check("wash_sel_mode", int'(mode), 0);
        ticks(5);
        check("wash7_count", int'(count), 7);
        check("wash7_fan", int'(fan), 1);
        cyc(0, 0, 1, 0, 0);
        ticks(5);
        check("pause_count", int'(count), 7);
        check("pause_acts", acts(), 8'b0000_0001);
        cyc(0, 0, 1, 0, 0);
        check("resume_count", int'(count), 7);
        check("resume_acts", acts(), 8'b0100_0101);
        ticks(3);
        check("resume_zheng", int'(zheng), 1);
        ticks(16);
        check("wash_prog_done", int'(alarm), 1);
        cyc(0, 0, 1, 0, 0);

        // emergency with a tick during INLET
        cyc(0, 0, 1, 0, 0);
        ticks(2);
        cyc(0, 1, 0, 0, 1);
        check("estop_acts", acts(), 8'b0010_0011);
        check("estop_count", int'(count), 4);
        cyc(0, 0, 1, 0, 0);
        check("estop_start_acts", acts(), 8'b0010_0011);
        check("estop_start_count", int'(count), 4);
        cyc(1, 0, 0, 0, 0);
        check("estop_rst_acts", acts(), 0);
        check("estop_rst_count", int'(count), 0);

        // randomized traffic against the model
        estop_run = 0;
        for (int i = 0; i < 1500; i++) begin
            estop_run = (m_stat == c_estop) ? estop_run + 1 : 0;
            r  = ($urandom_range(0, 299) == 0) || (estop_run > 12);
            t  = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 24) == 0);
            sl = ($urandom_range(0, 7) == 0);
            em = ($urandom_range(0, 199) == 0);
            cyc(r, t, s, sl, em);
        end

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
